// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter.
// State encoding, requester count, select width and a one-hot helper.
package rr_mux_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    // Convert a requester index into its one-hot grant vector.
    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick4.sv
// Combinational round-robin picker: returns the first set request bit,
// searching from index 'start' upward with wrap-around modulo 4.
module rr_mux_arbiter_pick4
    import rr_mux_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    logic [SEL_W-1:0]   off_s;

    // Rotate requests so bit 0 is 'start', then take the lowest set bit.
    always_comb begin
        dbl_s = {req, req} >> start;
        rot_s = dbl_s[N_REQ-1:0];
        found = 1'b1;
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: begin
                off_s = 2'd0;
                found = 1'b0;
            end
        endcase
        idx = start + off_s;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 output mux with a
// valid/ready downstream handshake. Grant is held until the sink accepts.
// Optional burst lock input is enabled by defining RR_ARB_LOCK_EN.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    input  logic                   out_ready,
`ifdef RR_ARB_LOCK_EN
    input  logic                   lock,
`endif
    output logic [N_REQ-1:0]       grant,
    output logic [SEL_W-1:0]       sel,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   busy
);

    state_t           state_r;
    logic [SEL_W-1:0] last_r;

    logic [N_REQ-1:0] pick_req_s;
    logic [SEL_W-1:0] pick_start_s;
    logic             pick_found_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic             xfer_s;
    logic             lock_hold_s;

    assign xfer_s = out_valid & out_ready;

`ifdef RR_ARB_LOCK_EN
    assign lock_hold_s = lock & req[sel];
`else
    assign lock_hold_s = 1'b0;
`endif

    // Picker inputs: fresh arbitration from IDLE, or re-arbitration on a
    // transfer that excludes the current winner and starts after it.
    always_comb begin
        if (state_r == ST_GRANTED) begin
            pick_req_s   = req & ~grant;
            pick_start_s = sel + 2'd1;
        end else begin
            pick_req_s   = req;
            pick_start_s = last_r + 2'd1;
        end
    end

    rr_mux_arbiter_pick4 u_pick (
        .req   (pick_req_s),
        .start (pick_start_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Arbitration state machine with registered grant/sel/valid/busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            last_r    <= 2'd3;
            grant     <= 4'b0000;
            sel       <= 2'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r   <= ST_GRANTED;
                        grant     <= onehot4(pick_idx_s);
                        sel       <= pick_idx_s;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_GRANTED: begin
                    if (xfer_s) begin
                        if (lock_hold_s) begin
                            // Burst: keep the same requester, last untouched.
                            state_r <= ST_GRANTED;
                        end else if (pick_found_s) begin
                            last_r  <= sel;
                            grant   <= onehot4(pick_idx_s);
                            sel     <= pick_idx_s;
                        end else begin
                            last_r    <= sel;
                            state_r   <= ST_IDLE;
                            grant     <= 4'b0000;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end else if (!req[sel]) begin
                        // Withdrawal: drop the grant without moving priority.
                        state_r   <= ST_IDLE;
                        grant     <= 4'b0000;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        state_r <= ST_GRANTED;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    grant     <= 4'b0000;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Output mux driven by the registered select off the live requester data.
    always_comb begin
        case (sel)
            2'd0:    out_data = data_in[0*WIDTH +: WIDTH];
            2'd1:    out_data = data_in[1*WIDTH +: WIDTH];
            2'd2:    out_data = data_in[2*WIDTH +: WIDTH];
            2'd3:    out_data = data_in[3*WIDTH +: WIDTH];
            default: out_data = data_in[0*WIDTH +: WIDTH];
        endcase
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: stimulus pushes expected transfers,
// a negedge monitor pops and compares on every out_valid&out_ready cycle.
module tb_rr_mux_arbiter;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] data_in;
    logic               out_ready;
    logic               lock;
    logic [3:0]         grant;
    logic [1:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               busy;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [3:0] g, input logic [1:0] s,
                            input logic v, input logic b);
        chk({name, "_grant"}, {28'd0, grant}, {28'd0, g});
        chk({name, "_sel"}, {30'd0, sel}, {30'd0, s});
        chk({name, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({name, "_busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] s, input logic [7:0] d);
        exp_t e;
        e.grant = g;
        e.sel   = s;
        e.data  = d;
        sb_q.push_back(e);
    endtask

    // Monitor: invariant check and scoreboard compare on each accepted word.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            checks++;
            if (grant !== (4'b0001 << sel)) begin
                errors++;
                $display("FAIL onehot_inv actual grant=%b required=onehot(sel=%0d)", grant, sel);
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer actual grant=%b sel=%0d data=%h required none", grant, sel, out_data);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (grant !== e.grant || sel !== e.sel || out_data !== e.data) begin
                    errors++;
                    $display("FAIL xfer actual grant=%b sel=%0d data=%h required grant=%b sel=%0d data=%h",
                             grant, sel, out_data, e.grant, e.sel, e.data);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;
        lock      = 1'b0;
        data_in   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Reset with all requests pending.
        step();
        step();
        chk_outs("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Full rotation, back-to-back, starting at requester 0.
        push(4'b0001, 2'd0, 8'hA0);
        push(4'b0010, 2'd1, 8'hA1);
        push(4'b0100, 2'd2, 8'hA2);
        push(4'b1000, 2'd3, 8'hA3);
        push(4'b0001, 2'd0, 8'hA0);
        rst = 1'b0;
        step();
        chk_outs("rr0", 4'b0001, 2'd0, 1'b1, 1'b1);
        step();
        chk_outs("rr1", 4'b0010, 2'd1, 1'b1, 1'b1);
        step();
        chk_outs("rr2", 4'b0100, 2'd2, 1'b1, 1'b1);
        step();
        chk_outs("rr3", 4'b1000, 2'd3, 1'b1, 1'b1);
        step();
        chk_outs("rr4", 4'b0001, 2'd0, 1'b1, 1'b1);
        req = 4'b0000;
        step();
        chk_outs("rr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single requester held under backpressure, then one transfer.
        data_in[2*WIDTH +: WIDTH] = 8'h5C;
        req       = 4'b0100;
        out_ready = 1'b0;
        step();
        chk_outs("hold0", 4'b0100, 2'd2, 1'b1, 1'b1);
        chk("hold0_data", {24'd0, out_data}, 32'h5C);
        step();
        chk_outs("hold1", 4'b0100, 2'd2, 1'b1, 1'b1);
        step();
        chk_outs("hold2", 4'b0100, 2'd2, 1'b1, 1'b1);
        data_in[2*WIDTH +: WIDTH] = 8'h5D;
        #1;
        chk("live_data", {24'd0, out_data}, 32'h5D);
        data_in[2*WIDTH +: WIDTH] = 8'h5C;
        push(4'b0100, 2'd2, 8'h5C);
        out_ready = 1'b1;
        step();
        req = 4'b0000;
        chk_outs("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        data_in[2*WIDTH +: WIDTH] = 8'hA2;

        // Set last=0, then 3 must win over 0.
        push(4'b0001, 2'd0, 8'hA0);
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        push(4'b1000, 2'd3, 8'hA3);
        push(4'b0001, 2'd0, 8'hA0);
        req = 4'b1001;
        step();
        chk_outs("fair3", 4'b1000, 2'd3, 1'b1, 1'b1);
        step();
        chk_outs("fair0", 4'b0001, 2'd0, 1'b1, 1'b1);
        req = 4'b0000;
        step();
        chk_outs("fair_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Withdrawal leaves last at 0, so 0011 grants 1 next.
        out_ready = 1'b0;
        req       = 4'b0010;
        step();
        chk_outs("wd_grant", 4'b0010, 2'd1, 1'b1, 1'b1);
        req = 4'b0000;
        step();
        chk_outs("wd_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        req = 4'b0011;
        step();
        chk_outs("wd_regrant", 4'b0010, 2'd1, 1'b1, 1'b1);

        // Reset while granted under backpressure.
        rst = 1'b1;
        step();
        chk_outs("midrst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        req = 4'b1010;
        step();
        chk_outs("post_rst", 4'b0010, 2'd1, 1'b1, 1'b1);
        push(4'b0010, 2'd1, 8'hA1);
        out_ready = 1'b1;
        req       = 4'b0000;
        step();
        chk_outs("post_rst_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

`ifdef RR_ARB_LOCK_EN
        // Burst lock keeps requester 0, releasing it hands over to 1.
        push(4'b0001, 2'd0, 8'hA0);
        push(4'b0001, 2'd0, 8'hA0);
        push(4'b0001, 2'd0, 8'hA0);
        lock = 1'b1;
        req  = 4'b0011;
        step();
        chk_outs("lock0", 4'b0001, 2'd0, 1'b1, 1'b1);
        step();
        chk_outs("lock1", 4'b0001, 2'd0, 1'b1, 1'b1);
        step();
        chk_outs("lock2", 4'b0001, 2'd0, 1'b1, 1'b1);
        lock = 1'b0;
        push(4'b0010, 2'd1, 8'hA1);
        step();
        chk_outs("unlock", 4'b0010, 2'd1, 1'b1, 1'b1);
        req = 4'b0000;
        step();
        chk_outs("lock_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
`endif

        step();
        step();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 multiplexer.
- Four requesters compete for one output channel; the block picks a winner, drives the mux select and one-hot grant, and holds the selection until the downstream sink accepts the word.
- Sits between the requester-side datapath and a single downstream consumer using a valid/ready handshake.

Parameters:
- WIDTH, 8, data width of each requester word and of out_data.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i = requester i.
- data_in  input  4*WIDTH  packed requester words; requester i at bits [i*WIDTH +: WIDTH].
- out_ready  input  1  downstream accepts out_data this cycle.
- grant  output  4  one-hot grant, registered; 0 when idle.
- sel  output  2  registered mux select = index of granted requester.
- out_valid  output  1  registered; out_data is valid.
- out_data  output  WIDTH  data_in word selected by sel; combinational mux off the live data_in.
- busy  output  1  high in state GRANTED.

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high.
- Reset values: grant=0, sel=0, out_valid=0, busy=0, state=IDLE, internal last pointer=3, so requester 0 has first priority after reset.
- out_data while out_valid=0: it is the data_in word at the current sel. It is don't-care for the bench; no X is allowed when inputs are known.
- States: IDLE, GRANTED.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise choose the winner by round robin: the first set req bit searching last+1, last+2, ... mod 4.
  - Next cycle: grant=onehot(winner), sel=winner, out_valid=1, state GRANTED.
  - Latency from req to grant/out_valid is 1 cycle.
- GRANTED, transfer case (out_valid and out_ready in the same cycle):
  - A transfer occurs; last <= sel.
  - Re-arbitrate in the same cycle using req & ~grant, with priority starting at sel+1.
  - If a candidate exists: next cycle grant/sel move to it and out_valid stays 1, giving back-to-back transfers with no bubble.
  - If no candidate: next cycle go to IDLE, grant=0, out_valid=0.
  - The winner's own req is ignored in the transfer cycle. If it still requests, it is served later in round-robin order, so it cannot starve the others.
- GRANTED, no transfer:
  - grant, sel and out_valid hold; out_data follows the live data_in of the granted requester.
- Withdrawal: if req[sel]==0 while GRANTED with no transfer, treat it as a withdrawal.
  - Next cycle go to IDLE, out_valid=0, grant=0.
  - last is not updated.
- Simultaneous transfer and withdrawal: a transfer takes precedence over withdrawal.
- Reset asserted mid-transfer: overrides everything; all outputs return to reset values the next cycle. Any pending word is dropped.
- Invariants: grant is always one-hot or zero; grant==onehot(sel) whenever out_valid=1.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - If lock=1 during a transfer cycle and req[sel]=1, the grant stays with the same requester (burst). No re-arbitration happens and last is not updated.
  - When lock=0, normal round robin resumes.
- Undefined: no lock port; behaviour is exactly as above.

Decomposition:
- Shared package rr_mux_pkg:
  - state encoding constants ST_IDLE=0, ST_GRANTED=1;
  - N_REQ=4;
  - SEL_W=2.
- One natural sub-module: rr_pick4, a combinational round-robin priority picker.
  - Inputs: req[3:0], start index[1:0].
  - Outputs: found, idx[1:0].
  - Instantiated once and fed either req (from IDLE) or req & ~grant (on transfer).
- The 4:1 output mux is inline or reuses the team's existing 4x1 mux cell per bit.

Test Plan:
- Reset with req=4'b1111: all outputs 0. Release rst, keep out_ready=1 → grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; out_data equals each requester's word (e.g. 8'hA0..8'hA3).
- Single requester, req=4'b0100, data_in[2]=8'h5C, out_ready=0 for 3 cycles → grant=0100, sel=2, out_valid=1, out_data=8'h5C held. out_ready=1 → one transfer, then IDLE with out_valid=0.
- Fairness: last=0, req=4'b1001, out_ready=1 → requester 3 is granted before requester 0.
- Withdrawal: granted requester 1, out_ready=0, drop req[1] → next cycle grant=0, out_valid=0. Then req=4'b0010 again → grant=0010, since last was not updated.
- Reset mid-operation: while GRANTED with out_ready=0, pulse rst → next cycle grant=0, sel=0, out_valid=0, busy=0. After release, req=4'b1010 → requester 1 granted first.
- With RR_ARB_LOCK_EN defined: lock=1, req=4'b0011, out_ready=1 → requester 0 is granted for every cycle lock stays high. Drop lock → the next grant goes to requester 1.
